spram_arb: RTL and testbench

Two-requester arbiter and sequencer for a single-port `spram` instance. It lets the core data port (requester 0) and a DMA/loader port (requester 1) share one RAM through a req/gnt/rvalid handshake. Requester 0 has priority, and a bounded-wait counter guarantees requester 1 forward progress. Per-byte enables are expanded into the RAM's bit-write mask, and read data is routed back to the owning requester.

---
 rtl/spram_arb_pkg.sv | 18 +
 rtl/spram.sv | 29 ++
 rtl/spram_arb_mem.sv | 82 ++++++++
 rtl/spram_arb.sv | 116 +++++++++++
 tb/tb_spram_arb.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter and its wrappers.
package spram_arb_pkg;

    // Number of requesters sharing the RAM.
    localparam int NUM_REQ = 2;

    // Identifies which requester owns a grant or a pending response.
    typedef enum logic [$clog2(NUM_REQ)-1:0] {
        SEL_M0 = 1'b0,
        SEL_M1 = 1'b1
    } req_sel_e;

    // Expands one byte enable into its 8-bit lane of the RAM bit-write mask.
    function automatic logic [7:0] be2bwm(input logic be);
        return {8{be}};
    endfunction

endpackage

// File: rtl/spram.sv
// Behavioural single-port RAM with per-bit write mask; Q updates only on reads.
module spram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             ce,
    input  logic             we,
    input  logic [AW-1:0]    a,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] bwm,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Masked write or registered read, one access per enabled cycle.
    always_ff @(posedge clk) begin
        if (ce) begin
            if (we) begin
                mem[a] <= (mem[a] & ~bwm) | (d & bwm);
            end else begin
                q <= mem[a];
            end
        end
    end

endmodule

// File: rtl/spram_arb_mem.sv
// Integration wrapper: arbiter plus the single-port RAM it sequences.
module spram_arb_mem #(
    parameter int DEPTH    = 1024,
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int NB = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             m0_req,
    output logic             m0_gnt,
    input  logic [AW-1:0]    m0_addr,
    input  logic             m0_we,
    input  logic [NB-1:0]    m0_be,
    input  logic [WIDTH-1:0] m0_wdata,
    output logic             m0_rvalid,
    output logic [WIDTH-1:0] m0_rdata,

    input  logic             m1_req,
    output logic             m1_gnt,
    input  logic [AW-1:0]    m1_addr,
    input  logic             m1_we,
    input  logic [NB-1:0]    m1_be,
    input  logic [WIDTH-1:0] m1_wdata,
    output logic             m1_rvalid,
    output logic [WIDTH-1:0] m1_rdata
);

    logic             ram_ce;
    logic             ram_we;
    logic [AW-1:0]    ram_a;
    logic [WIDTH-1:0] ram_d;
    logic [WIDTH-1:0] ram_bwm;
    logic [WIDTH-1:0] ram_q;

    spram_arb #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .MAX_WAIT (MAX_WAIT)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_gnt    (m0_gnt),
        .m0_addr   (m0_addr),
        .m0_we     (m0_we),
        .m0_be     (m0_be),
        .m0_wdata  (m0_wdata),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_gnt    (m1_gnt),
        .m1_addr   (m1_addr),
        .m1_we     (m1_we),
        .m1_be     (m1_be),
        .m1_wdata  (m1_wdata),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_a     (ram_a),
        .ram_d     (ram_d),
        .ram_bwm   (ram_bwm),
        .ram_q     (ram_q)
    );

    spram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk (clk),
        .ce  (ram_ce),
        .we  (ram_we),
        .a   (ram_a),
        .d   (ram_d),
        .bwm (ram_bwm),
        .q   (ram_q)
    );

endmodule

// File: rtl/spram_arb.sv
// Two-requester arbiter for a single-port RAM. Requester 0 has priority;
// requester 1 is forced through after MAX_WAIT consecutive refusals.
// Each accepted request gets exactly one rvalid one cycle after its grant.
module spram_arb
    import spram_arb_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int NB = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             m0_req,
    output logic             m0_gnt,
    input  logic [AW-1:0]    m0_addr,
    input  logic             m0_we,
    input  logic [NB-1:0]    m0_be,
    input  logic [WIDTH-1:0] m0_wdata,
    output logic             m0_rvalid,
    output logic [WIDTH-1:0] m0_rdata,

    input  logic             m1_req,
    output logic             m1_gnt,
    input  logic [AW-1:0]    m1_addr,
    input  logic             m1_we,
    input  logic [NB-1:0]    m1_be,
    input  logic [WIDTH-1:0] m1_wdata,
    output logic             m1_rvalid,
    output logic [WIDTH-1:0] m1_rdata,

    output logic             ram_ce,
    output logic             ram_we,
    output logic [AW-1:0]    ram_a,
    output logic [WIDTH-1:0] ram_d,
    output logic [WIDTH-1:0] ram_bwm,
    input  logic [WIDTH-1:0] ram_q
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [WW-1:0] wait_cnt;
    logic          force_m1;
    logic [NB-1:0] be_sel;

    logic          resp_v;
    req_sel_e      resp_sel;
    logic          resp_rd;

    // Grants are purely combinational so a request can be accepted in its first cycle.
    assign force_m1 = m1_req && (wait_cnt == WW'(MAX_WAIT));
    assign m1_gnt   = m1_req && (!m0_req || force_m1);
    assign m0_gnt   = m0_req && !m1_gnt;
    assign ram_ce   = m0_gnt | m1_gnt;

    // Route the granted requester's payload to the RAM; everything is zero when idle.
    always_comb begin
        ram_we = 1'b0;
        ram_a  = '0;
        ram_d  = '0;
        be_sel = '0;
        if (m1_gnt) begin
            ram_we = m1_we;
            ram_a  = m1_addr;
            ram_d  = m1_wdata;
            if (m1_we) be_sel = m1_be;
        end else if (m0_gnt) begin
            ram_we = m0_we;
            ram_a  = m0_addr;
            ram_d  = m0_wdata;
            if (m0_we) be_sel = m0_be;
        end
    end

    // Byte enables become the bit mask; reads leave be_sel zero so the mask stays clear.
    for (genvar i = 0; i < NB; i++) begin : g_bwm
        assign ram_bwm[8*i +: 8] = be2bwm(be_sel[i]);
    end

    // Count consecutive refusals of requester 1; a grant or a dropped request restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (m1_req && !m1_gnt) begin
            if (wait_cnt != WW'(MAX_WAIT)) wait_cnt <= wait_cnt + WW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Remember who was granted and whether it was a read, for the next-cycle response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_v   <= 1'b0;
            resp_sel <= SEL_M0;
            resp_rd  <= 1'b0;
        end else if (ram_ce) begin
            resp_v   <= 1'b1;
            resp_sel <= m1_gnt ? SEL_M1 : SEL_M0;
            resp_rd  <= !ram_we;
        end else begin
            resp_v   <= 1'b0;
        end
    end

    // Steer the response to its owner; write responses carry zero data.
    always_comb begin
        m0_rvalid = resp_v && (resp_sel == SEL_M0);
        m1_rvalid = resp_v && (resp_sel == SEL_M1);
        m0_rdata  = (m0_rvalid && resp_rd) ? ram_q : '0;
        m1_rdata  = (m1_rvalid && resp_rd) ? ram_q : '0;
    end

endmodule

// File: tb/tb_spram_arb.sv
// Self-checking bench for spram_arb: directed scenarios followed by random
// traffic, compared against a transaction-level model of the arbiter.
module tb_spram_arb;

    localparam int DEPTH    = 1024;
    localparam int WIDTH    = 32;
    localparam int MAX_WAIT = 4;
    localparam int AW       = 10;
    localparam int NB       = 4;

    typedef struct packed {
        logic             req;
        logic             we;
        logic [AW-1:0]    addr;
        logic [NB-1:0]    be;
        logic [WIDTH-1:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n;

    logic             m0_req, m0_gnt, m0_we, m0_rvalid;
    logic [AW-1:0]    m0_addr;
    logic [NB-1:0]    m0_be;
    logic [WIDTH-1:0] m0_wdata, m0_rdata;
    logic             m1_req, m1_gnt, m1_we, m1_rvalid;
    logic [AW-1:0]    m1_addr;
    logic [NB-1:0]    m1_be;
    logic [WIDTH-1:0] m1_wdata, m1_rdata;
    logic             ram_ce, ram_we;
    logic [AW-1:0]    ram_a;
    logic [WIDTH-1:0] ram_d, ram_bwm, ram_q;

    always #5 clk = ~clk;

    spram_arb #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_addr(m0_addr), .m0_we(m0_we),
        .m0_be(m0_be), .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_addr(m1_addr), .m1_we(m1_we),
        .m1_be(m1_be), .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_a(ram_a), .ram_d(ram_d),
        .ram_bwm(ram_bwm), .ram_q(ram_q)
    );

    // RAM driven purely by the DUT's RAM-side pins.
    logic [WIDTH-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) ram[ram_a] <= (ram[ram_a] & ~ram_bwm) | (ram_d & ram_bwm);
            else        ram_q <= ram[ram_a];
        end
    end

    // Reference model state: expected memory, refusal count, pending responses.
    logic [WIDTH-1:0] ref_mem [DEPTH];
    int               refused;
    logic             p_rv0, p_rv1, e_g0, e_g1;
    logic [WIDTH-1:0] p_rd0, p_rd1;
    txn_t             s0, s1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input logic req, input logic we, input int addr,
                                input logic [NB-1:0] be, input logic [WIDTH-1:0] wdata);
        txn_t t;
        t.req   = req;
        t.we    = we;
        t.addr  = AW'(addr);
        t.be    = be;
        t.wdata = wdata;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.req   = ($urandom_range(0, 99) < 60);
        t.we    = $urandom_range(0, 1) == 1;
        t.addr  = AW'($urandom_range(0, 15));
        t.be    = NB'($urandom);
        t.wdata = $urandom;
        return t;
    endfunction

    task automatic apply();
        m0_req = s0.req; m0_we = s0.we; m0_addr = s0.addr; m0_be = s0.be; m0_wdata = s0.wdata;
        m1_req = s1.req; m1_we = s1.we; m1_addr = s1.addr; m1_be = s1.be; m1_wdata = s1.wdata;
    endtask

    // One clock cycle: drive staged requests, check every output against the model, advance the model.
    task automatic tick(input string tag);
        txn_t             g;
        logic [WIDTH-1:0] mask;
        logic             granted;
        @(negedge clk);
        apply();
        #1;
        check({tag, " m0_rvalid"}, m0_rvalid, p_rv0);
        check({tag, " m1_rvalid"}, m1_rvalid, p_rv1);
        check({tag, " m0_rdata"}, m0_rdata, p_rd0);
        check({tag, " m1_rdata"}, m1_rdata, p_rd1);
        check({tag, " rvalid_both"}, m0_rvalid & m1_rvalid, 1'b0);

        e_g1 = s1.req && (!s0.req || refused >= MAX_WAIT);
        e_g0 = s0.req && !e_g1;
        granted = e_g0 || e_g1;
        check({tag, " m0_gnt"}, m0_gnt, e_g0);
        check({tag, " m1_gnt"}, m1_gnt, e_g1);
        check({tag, " ram_ce"}, ram_ce, granted);

        g = e_g1 ? s1 : s0;
        mask = '0;
        for (int i = 0; i < NB; i++) if (g.we && g.be[i]) mask[8*i +: 8] = 8'hFF;
        if (granted) begin
            check({tag, " ram_we"}, ram_we, g.we);
            check({tag, " ram_a"}, ram_a, g.addr);
            check({tag, " ram_d"}, ram_d, g.wdata);
            check({tag, " ram_bwm"}, ram_bwm, mask);
        end else begin
            check({tag, " ram_idle"}, {ram_we, ram_a, ram_d, ram_bwm}, '0);
        end

        p_rv0 = e_g0;
        p_rv1 = e_g1;
        p_rd0 = '0;
        p_rd1 = '0;
        if (granted) begin
            if (g.we) ref_mem[g.addr] = (ref_mem[g.addr] & ~mask) | (g.wdata & mask);
            else if (e_g1) p_rd1 = ref_mem[g.addr];
            else p_rd0 = ref_mem[g.addr];
        end
        if (s1.req && !e_g1) refused = (refused < MAX_WAIT) ? refused + 1 : MAX_WAIT;
        else refused = 0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        s0 = '0;
        s1 = '0;
        apply();
        #1;
        check({tag, " outputs"}, {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid,
                                  ram_ce, ram_we, ram_a, ram_d, ram_bwm}, '0);
        check({tag, " m0_rdata"}, m0_rdata, '0);
        check({tag, " m1_rdata"}, m1_rdata, '0);
        @(negedge clk);
        rst_n = 1'b1;
        refused = 0;
        p_rv0 = 1'b0;
        p_rv1 = 1'b0;
        p_rd0 = '0;
        p_rd1 = '0;
        e_g0  = 1'b0;
        e_g1  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        s0 = '0;
        s1 = '0;
        apply();
        do_reset("reset");

        // Preload every address the bench will read.
        for (int a = 0; a < 16; a++) begin
            s0 = mk(1, 1, a, 4'hF, 32'hA500_0000 + a);
            tick("preload");
        end
        s0 = mk(1, 1, 100, 4'hF, 32'h0000_0064);
        tick("preload");

        // Single m0 write then read.
        s0 = mk(1, 1, 5, 4'hF, 32'hDEADBEEF);
        s1 = '0;
        tick("wr5");
        check("wr5 gnt", m0_gnt, 1'b1);
        s0 = mk(1, 0, 5, 4'h0, '0);
        tick("rd5");
        check("wr5 resp rvalid", m0_rvalid, 1'b1);
        check("wr5 resp rdata", m0_rdata, 32'h0);
        s0 = '0;
        tick("rd5 resp");
        check("rd5 rdata", m0_rdata, 32'hDEADBEEF);

        // Byte masking.
        s0 = mk(1, 1, 9, 4'hF, 32'h11223344);
        tick("bm pre");
        s0 = mk(1, 1, 9, 4'b0101, 32'hAABBCCDD);
        tick("bm wr");
        check("bm bwm", ram_bwm, 32'h00FF00FF);
        s0 = mk(1, 0, 9, 4'h0, '0);
        tick("bm rd");
        s0 = '0;
        tick("bm resp");
        check("bm readback", m0_rdata, 32'h11BB33DD);

        // Continuous contention: m1 forced every MAX_WAIT+1 cycles.
        tick("ct idle");
        s0 = mk(1, 0, 7, 4'h0, '0);
        s1 = mk(1, 0, 100, 4'h0, '0);
        for (int i = 0; i < 10; i++) begin
            tick("ct");
            check($sformatf("ct m1_gnt c%0d", i), m1_gnt, (i == 4 || i == 9));
            check($sformatf("ct m0_gnt c%0d", i), m0_gnt, !(i == 4 || i == 9));
        end
        s0 = '0;
        s1 = '0;
        tick("ct drain");

        // Interleaved reads from both requesters.
        s0 = mk(1, 1, 1, 4'hF, 32'h1);
        tick("il pre1");
        s0 = '0;
        s1 = mk(1, 1, 2, 4'hF, 32'h2);
        tick("il pre2");
        s1 = '0;
        tick("il idle");
        s0 = mk(1, 0, 1, 4'h0, '0);
        tick("il n");
        s0 = '0;
        s1 = mk(1, 0, 2, 4'h0, '0);
        tick("il n+1");
        check("il m0_rvalid n+1", m0_rvalid, 1'b1);
        check("il m0_rdata n+1", m0_rdata, 32'h1);
        check("il m1_rvalid n+1", m1_rvalid, 1'b0);
        s1 = '0;
        tick("il n+2");
        check("il m1_rvalid n+2", m1_rvalid, 1'b1);
        check("il m1_rdata n+2", m1_rdata, 32'h2);
        check("il m0_rvalid n+2", m0_rvalid, 1'b0);

        // m1 dropped after two refusals, then reissued: a fresh wait is needed.
        s0 = mk(1, 0, 3, 4'h0, '0);
        s1 = mk(1, 0, 4, 4'h0, '0);
        tick("drop r1");
        tick("drop r2");
        s1 = '0;
        tick("drop gap");
        s1 = mk(1, 0, 4, 4'h0, '0);
        for (int i = 0; i < 5; i++) begin
            tick("drop re");
            check($sformatf("drop m1_gnt c%0d", i), m1_gnt, (i == 4));
        end
        s0 = '0;
        s1 = '0;
        tick("drop drain");

        // Reset with an m0 read response pending.
        s0 = mk(1, 0, 5, 4'h0, '0);
        tick("rp grant");
        check("rp gnt", m0_gnt, 1'b1);
        do_reset("rp reset");
        s0 = '0;
        tick("rp after");
        check("rp no rvalid", m0_rvalid, 1'b0);
        tick("rp after2");

        // Random traffic; a refused request holds its payload until granted.
        s0 = '0;
        s1 = '0;
        for (int c = 0; c < 600; c++) begin
            if (!s0.req || e_g0) s0 = rand_txn();
            if (!s1.req || e_g1) s1 = rand_txn();
            tick("rnd");
        end
        s0 = '0;
        s1 = '0;
        tick("rnd drain");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
